blake2s_round_core: RTL and testbench

Compression engine for BLAKE2s that sits directly downstream of the message-word schedule. It drives `round` and `mode` into the schedule and consumes the eight selected 32-bit message words each cycle. It runs four G functions in parallel per cycle, alternating column and diagonal steps, for 10 rounds (20 steps). It then produces the updated 256-bit chaining value.

---
 rtl/blake2s_round_core.sv | 162 ++++++++++++++++
 tb/tb_blake2s_round_core.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2s_round_core.sv
// BLAKE2s compression engine: four parallel G functions per cycle, 20 column/diagonal steps,
// driving round/mode to an external message schedule and producing the updated chaining value.
module blake2s_round_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [255:0] h_in,
  input  logic [63:0]  t_in,
  input  logic         last,
  output logic [3:0]   round,
  output logic         mode,
  input  logic [31:0]  G0_m0,
  input  logic [31:0]  G0_m1,
  input  logic [31:0]  G1_m0,
  input  logic [31:0]  G1_m1,
  input  logic [31:0]  G2_m0,
  input  logic [31:0]  G2_m1,
  input  logic [31:0]  G3_m0,
  input  logic [31:0]  G3_m1,
  output logic         ready,
  output logic [255:0] h_out,
  output logic         h_valid
);

  localparam logic [255:0] IvAll = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                    32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
  localparam logic [3:0] LastRound = 4'd9;

  typedef enum logic [1:0] {StIdle, StRounds, StFinish} state_e;

  state_e        state_q;
  logic [3:0]    round_q;
  logic          mode_q;
  logic [31:0]   v_q [16];
  logic [31:0]   h_q [8];
  logic [255:0]  h_out_q;
  logic          h_valid_q;

  logic [31:0]   v_d [16];
  logic [31:0]   ga [4];
  logic [31:0]   gb [4];
  logic [31:0]   gc [4];
  logic [31:0]   gd [4];
  logic [31:0]   gm0 [4];
  logic [31:0]   gm1 [4];
  logic [127:0]  gr [4];

  function automatic logic [127:0] g_mix(input logic [31:0] a_in, input logic [31:0] b_in,
                                         input logic [31:0] c_in, input logic [31:0] d_in,
                                         input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b, c, d, t;
    a = a_in + b_in + x;
    t = d_in ^ a;
    d = {t[15:0], t[31:16]};
    c = c_in + d;
    t = b_in ^ c;
    b = {t[11:0], t[31:12]};
    a = a + b + y;
    t = d ^ a;
    d = {t[7:0], t[31:8]};
    c = c + d;
    t = b ^ c;
    b = {t[6:0], t[31:7]};
    return {a, b, c, d};
  endfunction

  assign gm0[0] = G0_m0;
  assign gm1[0] = G0_m1;
  assign gm0[1] = G1_m0;
  assign gm1[1] = G1_m1;
  assign gm0[2] = G2_m0;
  assign gm1[2] = G2_m1;
  assign gm0[3] = G3_m0;
  assign gm1[3] = G3_m1;

  // Diagonal step rotates the b/c/d rows by one/two/three lanes relative to column step.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      v_d[k] = v_q[k];
    end
    for (int k = 0; k < 4; k++) begin
      ga[k] = v_q[k];
      if (mode_q) begin
        gb[k] = v_q[4 + ((k + 1) % 4)];
        gc[k] = v_q[8 + ((k + 2) % 4)];
        gd[k] = v_q[12 + ((k + 3) % 4)];
      end else begin
        gb[k] = v_q[4 + k];
        gc[k] = v_q[8 + k];
        gd[k] = v_q[12 + k];
      end
      gr[k] = g_mix(ga[k], gb[k], gc[k], gd[k], gm0[k], gm1[k]);
      v_d[k] = gr[k][127:96];
      if (mode_q) begin
        v_d[4 + ((k + 1) % 4)]  = gr[k][95:64];
        v_d[8 + ((k + 2) % 4)]  = gr[k][63:32];
        v_d[12 + ((k + 3) % 4)] = gr[k][31:0];
      end else begin
        v_d[4 + k]  = gr[k][95:64];
        v_d[8 + k]  = gr[k][63:32];
        v_d[12 + k] = gr[k][31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      round_q   <= '0;
      mode_q    <= 1'b0;
      h_out_q   <= '0;
      h_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) v_q[i] <= '0;
      for (int i = 0; i < 8; i++) h_q[i] <= '0;
    end else begin
      h_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (init) begin
            for (int i = 0; i < 8; i++) begin
              h_q[i] <= h_in[32*i +: 32];
              v_q[i] <= h_in[32*i +: 32];
            end
            for (int i = 0; i < 4; i++) v_q[8 + i] <= IvAll[32*i +: 32];
            v_q[12]  <= IvAll[32*4 +: 32] ^ t_in[31:0];
            v_q[13]  <= IvAll[32*5 +: 32] ^ t_in[63:32];
            v_q[14]  <= IvAll[32*6 +: 32] ^ {32{last}};
            v_q[15]  <= IvAll[32*7 +: 32];
            round_q  <= '0;
            mode_q   <= 1'b0;
            state_q  <= StRounds;
          end
        end
        StRounds: begin
          for (int i = 0; i < 16; i++) v_q[i] <= v_d[i];
          mode_q <= ~mode_q;
          if (mode_q) begin
            if (round_q == LastRound) begin
              round_q <= '0;
              state_q <= StFinish;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        StFinish: begin
          for (int i = 0; i < 8; i++) h_out_q[32*i +: 32] <= h_q[i] ^ v_q[i] ^ v_q[i + 8];
          h_valid_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign round   = round_q;
  assign mode    = mode_q;
  assign ready   = (state_q == StIdle);
  assign h_out   = h_out_q;
  assign h_valid = h_valid_q;

endmodule

// File: tb/tb_blake2s_round_core.sv
// Bench for blake2s_round_core: plays the message schedule and checks against a plain BLAKE2s
// compression model, known digests, step sequencing, busy-init, back-to-back and reset cases.
module tb_blake2s_round_core;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         init;
  logic [255:0] h_in;
  logic [63:0]  t_in;
  logic         last;
  logic [3:0]   round;
  logic         mode;
  logic [31:0]  G0_m0, G0_m1, G1_m0, G1_m1, G2_m0, G2_m1, G3_m0, G3_m1;
  logic         ready;
  logic [255:0] h_out;
  logic         h_valid;

  logic [511:0] msg;
  int           n_cmp = 0;
  int           n_bad = 0;

  localparam logic [255:0] IvAll = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                    32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
  localparam int Sigma [10][16] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
    '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
    '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
    '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
    '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
    '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
    '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
    '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}
  };

  blake2s_round_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (init),
    .h_in    (h_in),
    .t_in    (t_in),
    .last    (last),
    .round   (round),
    .mode    (mode),
    .G0_m0   (G0_m0),
    .G0_m1   (G0_m1),
    .G1_m0   (G1_m0),
    .G1_m1   (G1_m1),
    .G2_m0   (G2_m0),
    .G2_m1   (G2_m1),
    .G3_m0   (G3_m0),
    .G3_m1   (G3_m1),
    .ready   (ready),
    .h_out   (h_out),
    .h_valid (h_valid)
  );

  always #5 clk = ~clk;

  // Message schedule model: permuted words for the requested (round, mode).
  function automatic logic [31:0] sched_word(input logic [3:0] r, input logic md, input int g,
                                             input int j);
    int ri;
    ri = (r > 4'd9) ? 0 : int'(r);
    return msg[32 * Sigma[ri][(md ? 8 : 0) + 2 * g + j] +: 32];
  endfunction

  always_comb begin
    G0_m0 = sched_word(round, mode, 0, 0);
    G0_m1 = sched_word(round, mode, 0, 1);
    G1_m0 = sched_word(round, mode, 1, 0);
    G1_m1 = sched_word(round, mode, 1, 1);
    G2_m0 = sched_word(round, mode, 2, 0);
    G2_m1 = sched_word(round, mode, 2, 1);
    G3_m0 = sched_word(round, mode, 3, 0);
    G3_m1 = sched_word(round, mode, 3, 1);
  end

  function automatic logic [31:0] rotr(input logic [31:0] w, input int n);
    return (w >> n) | (w << (32 - n));
  endfunction

  function automatic logic [511:0] mix(input logic [511:0] v, input int a, input int b,
                                       input int c, input int d, input logic [31:0] x,
                                       input logic [31:0] y);
    logic [511:0] r;
    r = v;
    r[32*a +: 32] = r[32*a +: 32] + r[32*b +: 32] + x;
    r[32*d +: 32] = rotr(r[32*d +: 32] ^ r[32*a +: 32], 16);
    r[32*c +: 32] = r[32*c +: 32] + r[32*d +: 32];
    r[32*b +: 32] = rotr(r[32*b +: 32] ^ r[32*c +: 32], 12);
    r[32*a +: 32] = r[32*a +: 32] + r[32*b +: 32] + y;
    r[32*d +: 32] = rotr(r[32*d +: 32] ^ r[32*a +: 32], 8);
    r[32*c +: 32] = r[32*c +: 32] + r[32*d +: 32];
    r[32*b +: 32] = rotr(r[32*b +: 32] ^ r[32*c +: 32], 7);
    return r;
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] m,
                                                input logic [63:0] t, input logic lst);
    logic [511:0] v;
    logic [255:0] o;
    v = {IvAll, h};
    v[32*12 +: 32] ^= t[31:0];
    v[32*13 +: 32] ^= t[63:32];
    if (lst) v[32*14 +: 32] = ~v[32*14 +: 32];
    for (int r = 0; r < 10; r++) begin
      v = mix(v, 0, 4, 8, 12, m[32*Sigma[r][0] +: 32], m[32*Sigma[r][1] +: 32]);
      v = mix(v, 1, 5, 9, 13, m[32*Sigma[r][2] +: 32], m[32*Sigma[r][3] +: 32]);
      v = mix(v, 2, 6, 10, 14, m[32*Sigma[r][4] +: 32], m[32*Sigma[r][5] +: 32]);
      v = mix(v, 3, 7, 11, 15, m[32*Sigma[r][6] +: 32], m[32*Sigma[r][7] +: 32]);
      v = mix(v, 0, 5, 10, 15, m[32*Sigma[r][8] +: 32], m[32*Sigma[r][9] +: 32]);
      v = mix(v, 1, 6, 11, 12, m[32*Sigma[r][10] +: 32], m[32*Sigma[r][11] +: 32]);
      v = mix(v, 2, 7, 8, 13, m[32*Sigma[r][12] +: 32], m[32*Sigma[r][13] +: 32]);
      v = mix(v, 3, 4, 9, 14, m[32*Sigma[r][14] +: 32], m[32*Sigma[r][15] +: 32]);
    end
    o = h ^ v[255:0] ^ v[511:256];
    return o;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [511:0] rand512();
    return {rand256(), rand256()};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; init is sampled on the following rising edge (E0).
  task automatic drive_init(input logic [255:0] h, input logic [511:0] m, input logic [63:0] t,
                            input logic lst);
    h_in = h;
    msg  = m;
    t_in = t;
    last = lst;
    init = 1'b1;
  endtask

  // Steps through E1..E21; returns at the negedge of the h_valid cycle.
  task automatic run_steps(input string tag, input int busy_at, input logic [255:0] exp);
    @(negedge clk);
    init = 1'b0;
    for (int s = 0; s < 20; s++) begin
      check({tag, "_sched"}, {250'd0, ready, h_valid, round, mode},
            {250'd0, 1'b0, 1'b0, 4'(s / 2), 1'(s % 2)});
      if (s == busy_at) begin
        init = 1'b1;
        h_in = rand256();
      end
      @(negedge clk);
      init = 1'b0;
    end
    check({tag, "_finish"}, {250'd0, ready, h_valid, round, mode}, 256'd0);
    @(negedge clk);
    check({tag, "_valid"}, {254'd0, ready, h_valid}, 256'd3);
    check({tag, "_hout"}, h_out, exp);
  endtask

  logic [255:0] h_abc;
  logic [511:0] m_abc;
  logic [255:0] exp_abc;
  logic [255:0] exp_empty;
  logic [255:0] h_r, exp_r;
  logic [511:0] m_r;
  logic [63:0]  t_r;
  logic         l_r;
  int           vcount;

  initial begin
    reset_n = 1'b1;
    init    = 1'b0;
    h_in    = '0;
    t_in    = '0;
    last    = 1'b0;
    msg     = '0;
    h_abc   = IvAll ^ 256'h01010020;
    m_abc   = 512'h00636261;
    exp_abc   = ref_compress(h_abc, m_abc, 64'd3, 1'b1);
    exp_empty = ref_compress(h_abc, 512'd0, 64'd0, 1'b1);

    // Asynchronous reset asserted mid-cycle
    #13 reset_n = 1'b0;
    #1;
    check("rst_hout", h_out, 256'd0);
    check("rst_ctrl", {249'd0, ready, h_valid, round, mode}, {249'd0, 1'b1, 1'b0, 4'd0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    drive_init(h_abc, m_abc, 64'd3, 1'b1);
    run_steps("abc", -1, exp_abc);
    check("abc_w0", {224'd0, h_out[31:0]}, {224'd0, 32'h8C5E8C50});
    check("abc_w7", {224'd0, h_out[255:224]}, {224'd0, 32'h82596786});
    @(negedge clk);
    check("abc_pulse", {255'd0, h_valid}, 256'd0);
    check("abc_hold", h_out, exp_abc);

    drive_init(h_abc, 512'd0, 64'd0, 1'b1);
    run_steps("empty", -1, exp_empty);
    check("empty_w0", {224'd0, h_out[31:0]}, {224'd0, 32'h307A2169});
    check("empty_w7", {224'd0, h_out[255:224]}, {224'd0, 32'hF9EED01E});
    @(negedge clk);

    // Busy init at E5 ignored, then a back-to-back block sampled at E22
    drive_init(h_abc, m_abc, 64'd3, 1'b1);
    run_steps("busy", 4, exp_abc);
    h_r = rand256();
    m_r = rand512();
    t_r = {$urandom, $urandom};
    drive_init(h_r, m_r, t_r, 1'b0);
    run_steps("b2b", -1, ref_compress(h_r, m_r, t_r, 1'b0));
    @(negedge clk);

    // Reset at E10: no h_valid, then a clean rerun
    drive_init(h_abc, m_abc, 64'd3, 1'b1);
    @(negedge clk);
    init = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {249'd0, ready, h_valid, round, mode}, {249'd0, 1'b1, 1'b0, 4'd0, 1'b0});
    check("midrst_hout", h_out, 256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    vcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (h_valid) vcount++;
    end
    check("midrst_novalid", 256'(vcount), 256'd0);
    drive_init(h_abc, m_abc, 64'd3, 1'b1);
    run_steps("rerun", -1, exp_abc);

    // Random blocks, chained back-to-back
    for (int i = 0; i < 4; i++) begin
      h_r   = rand256();
      m_r   = rand512();
      t_r   = {$urandom, $urandom};
      l_r   = 1'($urandom_range(1));
      exp_r = ref_compress(h_r, m_r, t_r, l_r);
      drive_init(h_r, m_r, t_r, l_r);
      run_steps("rand", -1, exp_r);
    end
    @(negedge clk);
    check("final_pulse", {255'd0, h_valid}, 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
